// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the execute stage.
// Single-cycle ops are resolved at accept and presented the next cycle.
// MUL is an iterative shift-add unit. DIVU/REMU is a restoring divider.
// Both multi-cycle units produce one bit per cycle.
// One operation is in flight at a time. A valid/ready handshake is used on both sides.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluresult,
    output logic [3:0]       flags,
    output logic             div0
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_ROR  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_SLTU = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_DIVU = 4'hE;
    localparam logic [3:0] OP_REMU = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   x_q;      // MUL: multiplicand shifted left; DIV: divisor
    logic [WIDTH-1:0]   y_q;      // MUL: multiplier shifted right; DIV: dividend -> quotient
    logic [WIDTH-1:0]   acc_q;    // MUL: partial product; DIV: partial remainder
    logic [WIDTH-1:0]   a_q;      // original dividend, returned by REMU on a zero divisor
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   res_q;
    logic [3:0]         flags_q;
    logic               div0_q;

    // {N,Z,C,V} from a result plus the carry/overflow bits of the op
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r[WIDTH-1], (r == {WIDTH{1'b0}}), c, v};
    endfunction

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at accept
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SHW-1:0]   shift_neg_s;
    logic             add_v_s;
    logic             sub_v_s;
    logic [WIDTH-1:0] sc_res_s;
    logic             sc_c_s;
    logic             sc_v_s;

    assign sum_s       = {1'b0, srca} + {1'b0, srcb};
    assign diff_s      = {1'b0, srca} - {1'b0, srcb};
    // (WIDTH - shift) mod WIDTH. A zero shift makes both rotate halves equal to srca.
    assign shift_neg_s = {SHW{1'b0}} - shift;
    assign add_v_s     = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum_s[WIDTH-1] != srca[WIDTH-1]);
    assign sub_v_s     = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff_s[WIDTH-1] != srca[WIDTH-1]);

    // Select the single-cycle result and its carry/overflow
    always_comb begin
        sc_res_s = {WIDTH{1'b0}};
        sc_c_s   = 1'b0;
        sc_v_s   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res_s = sum_s[WIDTH-1:0];
                sc_c_s   = sum_s[WIDTH];
                sc_v_s   = add_v_s;
            end
            OP_SUB: begin
                sc_res_s = diff_s[WIDTH-1:0];
                sc_c_s   = ~diff_s[WIDTH];
                sc_v_s   = sub_v_s;
            end
            OP_OR:   sc_res_s = srca | srcb;
            OP_AND:  sc_res_s = srca & srcb;
            OP_XOR:  sc_res_s = srca ^ srcb;
            OP_NOR:  sc_res_s = ~(srca | srcb);
            OP_SLL:  sc_res_s = srca << shift;
            OP_ROL:  sc_res_s = (srca << shift) | (srca >> shift_neg_s);
            OP_SRL:  sc_res_s = srca >> shift;
            OP_SRA:  sc_res_s = $signed(srca) >>> shift;
            OP_ROR:  sc_res_s = (srca >> shift) | (srca << shift_neg_s);
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (srca < srcb)};
            OP_MUL, OP_DIVU, OP_REMU: sc_res_s = {WIDTH{1'b0}};
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH:0]   div_diff_s;
    logic             div_fit_s;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_quo_d;
    logic             div_by0_s;
    logic             cnt_last_s;
    logic [WIDTH-1:0] div_res_s;

    assign mul_acc_d   = acc_q + (y_q[0] ? x_q : {WIDTH{1'b0}});
    // Shift the next dividend bit (MSB first) into the partial remainder and trial-subtract
    assign div_trial_s = {acc_q, y_q[WIDTH-1]};
    assign div_diff_s  = div_trial_s - {1'b0, x_q};
    assign div_fit_s   = ~div_diff_s[WIDTH];
    assign div_rem_d   = div_fit_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
    assign div_quo_d   = {y_q[WIDTH-2:0], div_fit_s};
    assign div_by0_s   = (x_q == {WIDTH{1'b0}});
    assign cnt_last_s  = (cnt_q == CNT_W'(WIDTH - 1));

    // Final divider result, with forced values for a zero divisor
    always_comb begin
        div_res_s = div_rem_d;
        if (div_by0_s) begin
            if (op_q == OP_DIVU) begin
                div_res_s = {WIDTH{1'b1}};
            end else begin
                div_res_s = a_q;
            end
        end else begin
            if (op_q == OP_DIVU) begin
                div_res_s = div_quo_d;
            end else begin
                div_res_s = div_rem_d;
            end
        end
    end

    // Control FSM with registered result, flags and div0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            x_q     <= {WIDTH{1'b0}};
            y_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            flags_q <= 4'h0;
            div0_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        acc_q <= {WIDTH{1'b0}};
                        cnt_q <= {CNT_W{1'b0}};
                        if (op == OP_MUL) begin
                            x_q     <= srca;
                            y_q     <= srcb;
                            state_q <= ST_MUL;
                        end else if ((op == OP_DIVU) || (op == OP_REMU)) begin
                            x_q     <= srcb;
                            y_q     <= srca;
                            a_q     <= srca;
                            state_q <= ST_DIV;
                        end else begin
                            res_q   <= sc_res_s;
                            flags_q <= mk_flags(sc_res_s, sc_c_s, sc_v_s);
                            div0_q  <= 1'b0;
                            state_q <= ST_OUT;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_acc_d;
                    x_q   <= x_q << 1;
                    y_q   <= y_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_last_s) begin
                        res_q   <= mul_acc_d;
                        flags_q <= mk_flags(mul_acc_d, 1'b0, 1'b0);
                        div0_q  <= 1'b0;
                        state_q <= ST_OUT;
                    end
                end
                ST_DIV: begin
                    acc_q <= div_rem_d;
                    y_q   <= div_quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_last_s) begin
                        res_q   <= div_res_s;
                        flags_q <= mk_flags(div_res_s, 1'b0, 1'b0);
                        div0_q  <= div_by0_s;
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_OUT);
    assign aluresult = res_q;
    assign flags     = flags_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a scoreboard queue and a reference model.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [4:0]   shift;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] aluresult;
    logic [3:0]   flags;
    logic         div0;

    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   f;
        logic         d;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluresult (aluresult),
        .flags     (flags),
        .div0      (div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic [3:0] f, input logic d);
        exp_t e;
        e.r = r;
        e.f = f;
        e.d = d;
        return e;
    endfunction

    // Reference model
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] s);
        exp_t         e;
        logic [W:0]   t;
        longint       sa;
        longint       sbv;
        longint       sr;
        logic         c;
        logic         v;
        c   = 1'b0;
        v   = 1'b0;
        e.d = 1'b0;
        e.r = '0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            4'h0: begin
                t   = {1'b0, a} + {1'b0, b};
                e.r = t[W-1:0];
                c   = t[W];
                sr  = sa + sbv;
                v   = (sr != longint'($signed(e.r)));
            end
            4'h7: begin
                e.r = a - b;
                c   = (a >= b);
                sr  = sa - sbv;
                v   = (sr != longint'($signed(e.r)));
            end
            4'h1: e.r = a | b;
            4'h2: e.r = a & b;
            4'h3: e.r = a ^ b;
            4'h4: e.r = ~(a | b);
            4'h5: e.r = a << s;
            4'h6: begin
                e.r = a;
                for (int i = 0; i < int'(s); i++) e.r = {e.r[W-2:0], e.r[W-1]};
            end
            4'h8: e.r = a >> s;
            4'h9: e.r = $signed(a) >>> s;
            4'hA: begin
                e.r = a;
                for (int i = 0; i < int'(s); i++) e.r = {e.r[0], e.r[W-1:1]};
            end
            4'hB: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hC: e.r = (a < b) ? 32'd1 : 32'd0;
            4'hD: e.r = a * b;
            4'hE: begin
                e.d = (b == 32'd0);
                e.r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            end
            4'hF: begin
                e.d = (b == 32'd0);
                e.r = (b == 32'd0) ? a : a % b;
            end
            default: e.r = '0;
        endcase
        e.f = {e.r[W-1], (e.r == 32'd0), c, v};
        return e;
    endfunction

    // Drive one op from a negedge, push its expectation at accept, and wait for out_valid.
    // Returns at the negedge where out_valid is first seen.
    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] s, input exp_t e);
        int n;
        int lat;
        lat = (o >= 4'hD) ? W + 1 : 1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        op       = o;
        srca     = a;
        srcb     = b;
        shift    = s;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        srca     = $urandom;
        srcb     = $urandom;
        shift    = 5'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid) check_val("busy_in_ready", in_ready, 0);
        end while (!out_valid && n < 200);
        check_val("latency", n, lat);
        if (out_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Scoreboard: compare each result as it is handed over
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("result", aluresult, mon_e.r);
                check_val("flags", flags, mon_e.f);
                check_val("div0", div0, mon_e.d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [4:0]   rs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        srca      = '0;
        srcb      = '0;
        shift     = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_result", aluresult, 0);
        check_val("rst_flags", flags, 0);
        check_val("rst_div0", div0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed expectations
        send(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, mk(32'h8000_0000, 4'b1001, 1'b0));
        send(4'h7, 32'd5, 32'd5, 5'd0, mk(32'h0000_0000, 4'b0110, 1'b0));
        send(4'h7, 32'd3, 32'd5, 5'd0, mk(32'hFFFF_FFFE, 4'b1000, 1'b0));
        send(4'hB, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd1, 4'b0000, 1'b0));
        send(4'hC, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd0, 4'b0100, 1'b0));
        send(4'h9, 32'h8000_0000, 32'd0, 5'd4, mk(32'hF800_0000, 4'b1000, 1'b0));
        send(4'hA, 32'h0000_0001, 32'd0, 5'd1, mk(32'h8000_0000, 4'b1000, 1'b0));
        send(4'h6, 32'h1234_5678, 32'd0, 5'd0, mk(32'h1234_5678, 4'b0000, 1'b0));
        send(4'hD, 32'h0001_0001, 32'h0001_0001, 5'd0, mk(32'h0002_0001, 4'b0000, 1'b0));
        send(4'hE, 32'd100, 32'd7, 5'd0, mk(32'd14, 4'b0000, 1'b0));
        send(4'hF, 32'd100, 32'd7, 5'd0, mk(32'd2, 4'b0000, 1'b0));
        send(4'hE, 32'd9, 32'd0, 5'd0, mk(32'hFFFF_FFFF, 4'b1000, 1'b1));
        send(4'hF, 32'd9, 32'd0, 5'd0, mk(32'd9, 4'b0000, 1'b1));

        // Output back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        send(4'h0, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd0, 4'b0110, 1'b0));
        repeat (5) begin
            @(negedge clk);
            check_val("stall_valid", out_valid, 1);
            check_val("stall_result", aluresult, 0);
            check_val("stall_flags", flags, 4'b0110);
            check_val("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom);
            ra = $urandom;
            if (i % 5 == 0)                rb = 32'd0;
            else if ($urandom_range(0, 1)) rb = $urandom;
            else                           rb = 32'($urandom_range(1, 300));
            rs = 5'($urandom);
            send(ro, ra, rb, rs, model(ro, ra, rb, rs));
        end
        send(4'h3, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 5'd0, mk(32'hAAAA_AAAA, 4'b1000, 1'b0));

        // Reset in the middle of a multiply
        in_valid = 1'b1;
        op       = 4'hD;
        srca     = 32'h0000_1234;
        srcb     = 32'h0000_5678;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_val("mid_mul_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_out_valid", out_valid, 0);
        check_val("rst_mid_in_ready", in_ready, 1);
        check_val("rst_mid_result", aluresult, 0);
        check_val("rst_mid_flags", flags, 0);
        check_val("rst_mid_div0", div0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);
        check_val("abandoned_no_out", out_valid, 0);
        check_val("post_rst_in_ready", in_ready, 1);
        send(4'h0, 32'd2, 32'd3, 5'd0, mk(32'd5, 4'b0000, 1'b0));

        repeat (2) @(negedge clk);
        check_val("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
